// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single-port synchronous-read data memory between the multicycle
// CPU datapath (fixed priority) and a debug/loader master. Debug is protected
// from starvation by a saturating wait counter; read data is steered back to
// the requester that issued the read, one cycle after the grant.
//
// Optional build macro: DMEM_ARB_STATS_EN
//   When defined, adds saturating 16-bit counters of CPU grants, debug grants
//   and request-conflict cycles (stat_cpu_cnt, stat_dbg_cnt, stat_conflict_cnt).
//   When undefined, those ports and counters do not exist.
module dmem_port_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_cnt,
    output logic [15:0]       stat_dbg_cnt,
    output logic [15:0]       stat_conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

    logic              cpu_gnt_s;
    logic              dbg_gnt_s;
    logic              dbg_force_s;
    logic [3:0]        starve_cnt_r;
    owner_e            resp_owner_r;
    logic [DATA_W-1:0] cpu_hold_r;
    logic [DATA_W-1:0] dbg_hold_r;
    logic              cpu_rvalid_s;
    logic              dbg_rvalid_s;

    // Fixed-priority arbitration with a starvation override; no grants in reset.
    always_comb begin
        cpu_gnt_s   = 1'b0;
        dbg_gnt_s   = 1'b0;
        dbg_force_s = (starve_cnt_r == STARVE_LIMIT_C);
        if (rst) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else if (cpu_req && !dbg_force_s) begin
            cpu_gnt_s = 1'b1;
        end else if (dbg_req) begin
            dbg_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end
    end

    // Steer the winner's request fields onto the memory port; zeros when idle.
    always_comb begin
        mem_en    = cpu_gnt_s | dbg_gnt_s;
        mem_wen   = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (cpu_gnt_s) begin
            mem_wen   = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt_s) begin
            mem_wen   = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else begin
            mem_wen   = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Count consecutive denied debug-request cycles, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (dbg_gnt_s || !dbg_req) begin
            starve_cnt_r <= 4'd0;
        end else if (starve_cnt_r != STARVE_LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Remember who issued the read so its data lands on the right port next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner_r <= OWN_NONE;
        end else if (cpu_gnt_s && !cpu_we) begin
            resp_owner_r <= OWN_CPU;
        end else if (dbg_gnt_s && !dbg_we) begin
            resp_owner_r <= OWN_DBG;
        end else begin
            resp_owner_r <= OWN_NONE;
        end
    end

    // Decode the response owner into per-port valid strobes.
    always_comb begin
        cpu_rvalid_s = 1'b0;
        dbg_rvalid_s = 1'b0;
        case (resp_owner_r)
            OWN_CPU:  cpu_rvalid_s = 1'b1;
            OWN_DBG:  dbg_rvalid_s = 1'b1;
            OWN_NONE: begin
                cpu_rvalid_s = 1'b0;
                dbg_rvalid_s = 1'b0;
            end
            default: begin
                cpu_rvalid_s = 1'b0;
                dbg_rvalid_s = 1'b0;
            end
        endcase
    end

    // Capture returned read data so each port keeps showing its last read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_hold_r <= {DATA_W{1'b0}};
            dbg_hold_r <= {DATA_W{1'b0}};
        end else begin
            if (cpu_rvalid_s) begin
                cpu_hold_r <= mem_rdata;
            end else begin
                cpu_hold_r <= cpu_hold_r;
            end
            if (dbg_rvalid_s) begin
                dbg_hold_r <= mem_rdata;
            end else begin
                dbg_hold_r <= dbg_hold_r;
            end
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign dbg_gnt    = dbg_gnt_s;
    assign cpu_rvalid = cpu_rvalid_s;
    assign dbg_rvalid = dbg_rvalid_s;
    assign cpu_rdata  = cpu_rvalid_s ? mem_rdata : cpu_hold_r;
    assign dbg_rdata  = dbg_rvalid_s ? mem_rdata : dbg_hold_r;
    assign busy       = !rst & (cpu_req | dbg_req | cpu_rvalid_s | dbg_rvalid_s);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_cnt_r;
    logic [15:0] stat_dbg_cnt_r;
    logic [15:0] stat_conflict_cnt_r;

    // Saturating increment so long runs never wrap the statistics.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        logic [15:0] res;
        if (en && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Accumulate grant and conflict statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cpu_cnt_r      <= 16'd0;
            stat_dbg_cnt_r      <= 16'd0;
            stat_conflict_cnt_r <= 16'd0;
        end else begin
            stat_cpu_cnt_r      <= sat_inc(stat_cpu_cnt_r, cpu_gnt_s);
            stat_dbg_cnt_r      <= sat_inc(stat_dbg_cnt_r, dbg_gnt_s);
            stat_conflict_cnt_r <= sat_inc(stat_conflict_cnt_r, cpu_req & dbg_req);
        end
    end

    assign stat_cpu_cnt      = stat_cpu_cnt_r;
    assign stat_dbg_cnt      = stat_dbg_cnt_r;
    assign stat_conflict_cnt = stat_conflict_cnt_r;
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (13-bit word address, 32-bit data, synchronous read) between two requesters: the multicycle CPU datapath and a debug/loader master, e.g. switch-driven memory inspection on the seven-segment display.
- Sits between `datapath_multi`/debug logic and `data_mem`.
- The CPU has fixed priority. Debug is protected from starvation by a wait counter. Read data is routed back to the requester that issued the read.

Parameters:
- ADDR_W, 13, memory word-address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced priority (legal range 1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_req  in  1  CPU access request; held with fields stable until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req  in  1  debug access request; same rules as cpu_req
- dbg_we  in  1  1=write, 0=read
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug access issued this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_en  out  1  to data_mem en
- mem_wen  out  1  to data_mem wen
- mem_addr  out  ADDR_W  to data_mem addr
- mem_wdata  out  DATA_W  to data_mem data_in
- mem_rdata  in  DATA_W  from data_mem data_out; valid the cycle after a read is issued
- busy  out  1  any req pending or read response outstanding

Behaviour:
- Reset (async, rst=1): cpu_gnt/dbg_gnt/mem_en/mem_wen = 0, both rvalid = 0, both rdata holding registers = 0, starve_cnt = 0, resp_owner = NONE, busy = 0. Grants are forced 0 while rst is high, regardless of requests.
- Arbitration is combinational each cycle and yields at most one grant per cycle.
  - dbg_force = (starve_cnt == STARVE_LIMIT).
  - cpu_req and !dbg_force: grant CPU.
  - dbg_req and (!cpu_req or dbg_force): grant debug.
  - Otherwise: no grant.
- Memory side: mem_en = cpu_gnt|dbg_gnt. mem_wen, mem_addr and mem_wdata come from the winner. When idle: mem_wen = 0, addr/wdata = 0.
- Grant completes the handshake. The requester may change fields or drop req on the next edge. Back-to-back grants every cycle are legal.
- starve_cnt (registered):
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears on dbg_gnt or when dbg_req=0.
  - Saturates at STARVE_LIMIT.
- Read return:
  - On a granted read, resp_owner is registered (CPU/DBG) and the matching rvalid is asserted for exactly 1 cycle on the next edge.
  - In that cycle, rdata = mem_rdata. The per-port holding register also captures mem_rdata, and rdata shows the held value at all other times.
- Writes produce no rvalid. The non-owner port's rdata is unaffected.
- Simultaneous events:
  - A new grant in the same cycle as an outstanding rvalid is legal; the response pipeline is one deep and is fully pipelined.
  - CPU read followed immediately by debug read: cpu_rvalid at T+1, dbg_rvalid at T+2.
- busy = cpu_req|dbg_req|cpu_rvalid|dbg_rvalid.
- Reset mid-operation: an outstanding rvalid is dropped and never delivered, holding registers clear, starve_cnt clears.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN
- Defined: adds output ports stat_cpu_cnt[15:0], stat_dbg_cnt[15:0] and stat_conflict_cnt[15:0].
  - These count cpu grants, dbg grants, and cycles where both reqs are high.
  - Each counter saturates at 16'hFFFF and resets to 0 on rst.
- Not defined: the ports and counters are absent, and the arbitration behaviour is identical.

Test Plan:
- Reset with cpu_req=1 and rst=1 → no grants, mem_en=0, both rvalid=0. After rst falls, the first edge issues cpu_gnt=1.
- CPU write addr 0x010, data 0xDEADBEEF (granted cycle T); debug read addr 0x010 at T+1 → dbg_gnt at T+1, dbg_rvalid=1 with dbg_rdata=0xDEADBEEF at T+2, cpu_rvalid never asserted.
- cpu_req and dbg_req held high continuously, STARVE_LIMIT=4 → cpu_gnt on 4 cycles, dbg_gnt on 5th cycle, then CPU regains the grant and starve_cnt=0.
- CPU read addr 0x005 (mem holds 0x00001234) at T, debug read addr 0x006 (holds 0x0000ABCD) at T+1 → cpu_rvalid/0x00001234 at T+1, dbg_rvalid/0xABCD at T+2. cpu_rdata stays 0x00001234 afterward.
- Debug read granted at T, rst pulsed during T+1 → dbg_rvalid stays 0, dbg_rdata=0, busy=0.
- With DMEM_ARB_STATS_EN, 10 contended cycles at STARVE_LIMIT=4 → stat_conflict_cnt=10, stat_cpu_cnt=8, stat_dbg_cnt=2.
